// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared encodings, control word and helpers for the hardwired control unit
package cu_pkg;

  typedef logic [2:0] cuState;
  localparam cuState FETCH_L = 3'd0;
  localparam cuState FETCH_H = 3'd1;
  localparam cuState EXEC1   = 3'd2;
  localparam cuState EXEC2   = 3'd3;
  localparam cuState HALT    = 3'd7;

  localparam logic [5:0] OP_BRA  = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h01;
  localparam logic [5:0] OP_INC  = 6'h02;
  localparam logic [5:0] OP_DEC  = 6'h03;
  localparam logic [5:0] OP_MOVL = 6'h04;
  localparam logic [5:0] OP_ADD  = 6'h06;
  localparam logic [5:0] OP_SUB  = 6'h07;
  localparam logic [5:0] OP_AND  = 6'h08;
  localparam logic [5:0] OP_ORR  = 6'h09;
  localparam logic [5:0] OP_XOR  = 6'h0A;
  localparam logic [5:0] OP_LD   = 6'h0B;
  localparam logic [5:0] OP_ST   = 6'h0C;
  localparam logic [5:0] OP_HLT  = 6'h0D;

  localparam logic [2:0] FUN_DEC           = 3'b000;
  localparam logic [2:0] FUN_INC           = 3'b001;
  localparam logic [2:0] FUN_LOAD          = 3'b010;
  localparam logic [2:0] FUN_CLR_WRITE_LOW = 3'b100;

  localparam logic [4:0] ALU_PASS_A = 5'b10000;
  localparam logic [4:0] ALU_ADD    = 5'b10100;
  localparam logic [4:0] ALU_SUB    = 5'b10110;
  localparam logic [4:0] ALU_AND    = 5'b10111;
  localparam logic [4:0] ALU_ORR    = 5'b11000;
  localparam logic [4:0] ALU_XOR    = 5'b11001;

  localparam logic [2:0] SEL_S1     = 3'b100;
  localparam logic [3:0] SCR_EN_S1  = 4'b0111;
  localparam logic [1:0] ARF_OUT_PC = 2'b00;
  localparam logic [1:0] ARF_OUT_AR = 2'b10;
  localparam logic [2:0] ARF_EN_PC  = 3'b011;
  localparam logic [1:0] MUX_ALU    = 2'b00;
  localparam logic [1:0] MUX_MEM    = 2'b10;
  localparam logic [1:0] MUX_IR     = 2'b11;

  typedef struct packed {
    logic [2:0] rfOutASel;
    logic [2:0] rfOutBSel;
    logic [2:0] rfFunSel;
    logic [3:0] rfRegSel;
    logic [3:0] rfScrSel;
    logic [4:0] aluFunSel;
    logic       aluWf;
    logic [1:0] arfOutCSel;
    logic [1:0] arfOutDSel;
    logic [2:0] arfFunSel;
    logic [2:0] arfRegSel;
    logic       irLh;
    logic       irWrite;
    logic       memWr;
    logic       memCs;
    logic [1:0] muxASel;
    logic [1:0] muxBSel;
    logic       muxCSel;
    logic       halted;
    logic       illegal;
  } controlWord;

  function automatic controlWord idleWord();
    controlWord w;
    w = '0;
    w.rfRegSel  = 4'hF;
    w.rfScrSel  = 4'hF;
    w.arfRegSel = 3'h7;
    w.memCs     = 1'b1;
    return w;
  endfunction

  // R1..R4 sit at 100..111 on the register-file output muxes
  function automatic logic [2:0] rfOutSel(input logic [1:0] r);
    return {1'b1, r};
  endfunction

  // Active-low enable, R1 in the MSB
  function automatic logic [3:0] regEnLow(input logic [1:0] r);
    return ~(4'b1000 >> r);
  endfunction

  function automatic logic [4:0] aluCode(input logic [5:0] op);
    logic [4:0] code;
    code = ALU_ADD;
    case (op)
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_ORR:  code = ALU_ORR;
      OP_XOR:  code = ALU_XOR;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - combinational decode of state, IROut and flags into the datapath control word
module cu_decoder
  import cu_pkg::*;
(
  input  logic [15:0] IROut,
  input  logic [2:0]  state,
  input  logic [3:0]  Flags,
  output controlWord  ctrl
);

  logic [5:0] opcode;
  logic [1:0] rsel, src1, src2;
  logic       unusedBits;

  assign opcode     = IROut[15:10];
  assign rsel       = IROut[9:8];
  assign src1       = IROut[7:6];
  assign src2       = IROut[5:4];
  assign unusedBits = ^{IROut[3:0], Flags[2:0]};

  always_comb begin
    ctrl = idleWord();
    case (state)
      FETCH_L, FETCH_H: begin
        ctrl.arfOutDSel = ARF_OUT_PC;
        ctrl.memCs      = 1'b0;
        ctrl.irWrite    = 1'b1;
        ctrl.irLh       = (state == FETCH_H);
        ctrl.arfFunSel  = FUN_INC;
        ctrl.arfRegSel  = ARF_EN_PC;
      end
      EXEC1: begin
        case (opcode)
          OP_BRA, OP_BEQ: begin
            // Untaken BEQ falls through with no writes at all
            if (opcode == OP_BRA || Flags[3]) begin
              ctrl.muxASel  = MUX_IR;
              ctrl.rfFunSel = FUN_CLR_WRITE_LOW;
              ctrl.rfScrSel = SCR_EN_S1;
            end
          end
          OP_INC, OP_DEC: begin
            ctrl.rfFunSel = (opcode == OP_INC) ? FUN_INC : FUN_DEC;
            ctrl.rfRegSel = regEnLow(rsel);
          end
          OP_MOVL: begin
            ctrl.muxASel  = MUX_IR;
            ctrl.rfFunSel = FUN_CLR_WRITE_LOW;
            ctrl.rfRegSel = regEnLow(rsel);
          end
          OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_XOR: begin
            ctrl.rfOutASel = rfOutSel(src1);
            ctrl.rfOutBSel = rfOutSel(src2);
            ctrl.aluFunSel = aluCode(opcode);
            ctrl.aluWf     = 1'b1;
            ctrl.muxASel   = MUX_ALU;
            ctrl.rfFunSel  = FUN_LOAD;
            ctrl.rfRegSel  = regEnLow(rsel);
          end
          OP_LD: begin
            ctrl.arfOutDSel = ARF_OUT_AR;
            ctrl.memCs      = 1'b0;
            ctrl.muxASel    = MUX_MEM;
            ctrl.rfFunSel   = FUN_CLR_WRITE_LOW;
            ctrl.rfRegSel   = regEnLow(rsel);
          end
          OP_ST: begin
            ctrl.rfOutASel  = rfOutSel(rsel);
            ctrl.aluFunSel  = ALU_PASS_A;
            ctrl.muxCSel    = 1'b0;
            ctrl.arfOutDSel = ARF_OUT_AR;
            ctrl.memCs      = 1'b0;
            ctrl.memWr      = 1'b1;
          end
          OP_HLT: ;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      EXEC2: begin
        ctrl.rfOutASel = SEL_S1;
        ctrl.aluFunSel = ALU_PASS_A;
        ctrl.muxBSel   = MUX_ALU;
        ctrl.arfFunSel = FUN_LOAD;
        ctrl.arfRegSel = ARF_EN_PC;
      end
      HALT:    ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hardwired_control_unit.sv
// rtl/hardwired_control_unit.sv - fetch/execute sequencer driving the ArithmeticLogicUnitSystem datapath
module hardwired_control_unit
  import cu_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  Flags,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  SC,
  output logic        Halted,
  output logic        Illegal
);

  cuState     state, nextState;
  controlWord ctrl, word;
  logic [5:0] opcode;

  assign opcode = IROut[15:10];

  cu_decoder uDecoder (
    .IROut (IROut),
    .state (state),
    .Flags (Flags),
    .ctrl  (ctrl)
  );

  always_comb begin
    nextState = FETCH_L;
    case (state)
      FETCH_L: nextState = FETCH_H;
      FETCH_H: nextState = EXEC1;
      EXEC1: begin
        if (opcode == OP_BRA || (opcode == OP_BEQ && Flags[3]))
          nextState = EXEC2;
        else if (opcode == OP_HLT)
          nextState = HALT;
      end
      EXEC2:   nextState = FETCH_L;
      HALT:    nextState = HALT;
      default: nextState = FETCH_L;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= FETCH_L;
    else       state <= nextState;
  end

  // Gate with Reset so controls drop in the same instant the state is forced
  assign word = Reset ? idleWord() : ctrl;

  assign RF_OutASel  = word.rfOutASel;
  assign RF_OutBSel  = word.rfOutBSel;
  assign RF_FunSel   = word.rfFunSel;
  assign RF_RegSel   = word.rfRegSel;
  assign RF_ScrSel   = word.rfScrSel;
  assign ALU_FunSel  = word.aluFunSel;
  assign ALU_WF      = word.aluWf;
  assign ARF_OutCSel = word.arfOutCSel;
  assign ARF_OutDSel = word.arfOutDSel;
  assign ARF_FunSel  = word.arfFunSel;
  assign ARF_RegSel  = word.arfRegSel;
  assign IR_LH       = word.irLh;
  assign IR_Write    = word.irWrite;
  assign Mem_WR      = word.memWr;
  assign Mem_CS      = word.memCs;
  assign MuxASel     = word.muxASel;
  assign MuxBSel     = word.muxBSel;
  assign MuxCSel     = word.muxCSel;
  assign SC          = state;
  assign Halted      = word.halted;
  assign Illegal     = word.illegal;

endmodule

// File: tb/tb_hardwired_control_unit.sv
// tb/tb_hardwired_control_unit.sv - scoreboard bench for hardwired_control_unit
module tb_hardwired_control_unit;

  typedef struct packed {
    logic [2:0] sc;
    logic       halted, illegal;
    logic [2:0] rfA, rfB, rfFun;
    logic [3:0] rfReg, rfScr;
    logic [4:0] aluFun;
    logic       aluWf;
    logic [1:0] arfC, arfD;
    logic [2:0] arfFun, arfReg;
    logic       irLh, irWr, memWr, memCs;
    logic [1:0] muxA, muxB;
    logic       muxC;
  } ctlT;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  Flags;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [2:0]  SC;
  logic        Halted, Illegal;

  int compared = 0;
  int mismatched = 0;
  ctlT   expQ[$];
  string nameQ[$];

  hardwired_control_unit dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .Flags(Flags),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
    .ALU_WF(ALU_WF), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
    .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel),
    .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .SC(SC), .Halted(Halted), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  function automatic ctlT idle(input logic [2:0] sc);
    ctlT e = '0;
    e.sc = sc; e.rfReg = 4'hF; e.rfScr = 4'hF; e.arfReg = 3'h7; e.memCs = 1'b1;
    return e;
  endfunction

  function automatic ctlT fetch(input logic lh);
    ctlT e = idle({2'b00, lh});
    e.arfD = 2'b00; e.memCs = 1'b0; e.irWr = 1'b1; e.irLh = lh;
    e.arfFun = 3'b001; e.arfReg = 3'b011;
    return e;
  endfunction

  function automatic ctlT arith(input logic [2:0] a, input logic [2:0] b, input logic [4:0] alu,
                                input logic [3:0] reg_en);
    ctlT e = idle(3'd2);
    e.rfA = a; e.rfB = b; e.aluFun = alu; e.aluWf = 1'b1; e.muxA = 2'b00;
    e.rfFun = 3'b010; e.rfReg = reg_en;
    return e;
  endfunction

  // One clock of stimulus: drive inputs just after the edge, queue what the monitor must see
  task automatic cyc(input logic [15:0] ir, input logic [3:0] fl, input logic rst,
                     input ctlT e, input string name);
    IROut = ir; Flags = fl; Reset = rst;
    expQ.push_back(e);
    nameQ.push_back(name);
    @(posedge Clock); #1;
  endtask

  task automatic instr(input logic [15:0] ir, input logic [3:0] fl, input ctlT e1, input string name);
    cyc(ir, fl, 1'b0, fetch(1'b0), {name, "_fetchL"});
    cyc(ir, fl, 1'b0, fetch(1'b1), {name, "_fetchH"});
    cyc(ir, fl, 1'b0, e1, {name, "_exec1"});
  endtask

  initial begin : monitor
    ctlT act, e;
    string nm;
    forever begin
      @(negedge Clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        nm = nameQ.pop_front();
        act.sc = SC; act.halted = Halted; act.illegal = Illegal;
        act.rfA = RF_OutASel; act.rfB = RF_OutBSel; act.rfFun = RF_FunSel;
        act.rfReg = RF_RegSel; act.rfScr = RF_ScrSel; act.aluFun = ALU_FunSel;
        act.aluWf = ALU_WF; act.arfC = ARF_OutCSel; act.arfD = ARF_OutDSel;
        act.arfFun = ARF_FunSel; act.arfReg = ARF_RegSel; act.irLh = IR_LH;
        act.irWr = IR_Write; act.memWr = Mem_WR; act.memCs = Mem_CS;
        act.muxA = MuxASel; act.muxB = MuxBSel; act.muxC = MuxCSel;
        compared++;
        if (act !== e) begin
          mismatched++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
      end
    end
  end

  initial begin : stimulus
    ctlT e, e2, haltW;
    Reset = 1'b1; IROut = 16'h0; Flags = 4'h0;
    @(posedge Clock); #1;

    cyc(16'h0000, 4'h0, 1'b1, idle(3'd0), "reset_a");
    cyc(16'h0000, 4'h0, 1'b1, idle(3'd0), "reset_b");

    e = idle(3'd2); e.muxA = 2'b11; e.rfFun = 3'b100; e.rfReg = 4'b0111;
    instr(16'h105A, 4'h0, e, "movl_r1");

    instr(16'h1A10, 4'h0, arith(3'b100, 3'b101, 5'b10100, 4'b1101), "add_r3");
    instr(16'h1C00, 4'h0, arith(3'b100, 3'b100, 5'b10110, 4'b0111), "sub_r1");
    instr(16'h2360, 4'h0, arith(3'b101, 3'b110, 5'b10111, 4'b1110), "and_r4");
    instr(16'h24C0, 4'h0, arith(3'b111, 3'b100, 5'b11000, 4'b0111), "orr_r1");
    instr(16'h29B0, 4'h0, arith(3'b110, 3'b111, 5'b11001, 4'b1011), "xor_r2");

    // Taken branch: load S1 from IR, then PC from S1
    e = idle(3'd2); e.muxA = 2'b11; e.rfFun = 3'b100; e.rfScr = 4'b0111;
    e2 = idle(3'd3); e2.rfA = 3'b100; e2.aluFun = 5'b10000; e2.muxB = 2'b00;
    e2.arfFun = 3'b010; e2.arfReg = 3'b011;
    instr(16'h0420, 4'b1000, e, "beq_taken");
    cyc(16'h0420, 4'b1000, 1'b0, e2, "beq_taken_exec2");
    instr(16'h0420, 4'b0111, idle(3'd2), "beq_not_taken");
    instr(16'h0040, 4'h0, e, "bra");
    cyc(16'h0040, 4'h0, 1'b0, e2, "bra_exec2");

    e = idle(3'd2); e.rfA = 3'b101; e.aluFun = 5'b10000; e.muxC = 1'b0;
    e.arfD = 2'b10; e.memCs = 1'b0; e.memWr = 1'b1;
    instr(16'h3100, 4'h0, e, "st_r2");
    e = idle(3'd2); e.arfD = 2'b10; e.memCs = 1'b0; e.muxA = 2'b10;
    e.rfFun = 3'b100; e.rfReg = 4'b1110;
    instr(16'h2F00, 4'h0, e, "ld_r4");

    e = idle(3'd2); e.rfFun = 3'b001; e.rfReg = 4'b1011;
    instr(16'h0900, 4'h0, e, "inc_r2");
    e = idle(3'd2); e.rfFun = 3'b000; e.rfReg = 4'b1101;
    instr(16'h0E00, 4'h0, e, "dec_r3");

    e = idle(3'd2); e.illegal = 1'b1;
    instr(16'hFC00, 4'h0, e, "illegal_3f");
    instr(16'h1400, 4'h0, e, "illegal_05");

    // Async reset landing in EXEC2 of a branch
    e = idle(3'd2); e.muxA = 2'b11; e.rfFun = 3'b100; e.rfScr = 4'b0111;
    instr(16'h0080, 4'h0, e, "bra_rst");
    cyc(16'h0080, 4'h0, 1'b1, idle(3'd0), "rst_in_exec2");
    cyc(16'h0080, 4'h0, 1'b1, idle(3'd0), "rst_held");
    cyc(16'h0080, 4'h0, 1'b0, fetch(1'b0), "after_rst_fetchL");
    cyc(16'h0080, 4'h0, 1'b0, fetch(1'b1), "after_rst_fetchH");
    cyc(16'h0080, 4'h0, 1'b0, e, "after_rst_exec1");
    cyc(16'h0080, 4'h0, 1'b0, e2, "after_rst_exec2");

    instr(16'h3400, 4'h0, idle(3'd2), "hlt");
    haltW = idle(3'd7); haltW.halted = 1'b1;
    for (int i = 0; i < 100; i++)
      cyc(16'h3400, 4'h0, 1'b0, haltW, "halted");

    repeat (3) @(posedge Clock);
    if (expQ.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
